fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Forwarding and load-use hazard controller for the 5-stage pipeline. Drives the
//  2-bit selects of the two 3:1 ALU-operand muxes (00 regfile, 01 EX/MEM result,
//  10 MEM/WB result; 11 is never driven) and the load-use stall. Sits beside the
//  ID/EX register and keeps its own shadow of EX- and MEM-stage destination info.
// PARAMETERS
//  REG_W    5   register-specifier width
//  CNT_W    16  perf-counter width (used only with FWD_PERF_CNT_EN)
// PORTS
//  clk          in   1      pipeline clock, all state on rising edge
//  reset        in   1      synchronous, active-high
//  id_valid     in   1      ID holds a real instruction
//  id_rs        in   REG_W  ID source register A
//  id_rt        in   REG_W  ID source register B
//  id_use_rs    in   1      ID instruction reads rs
//  id_use_rt    in   1      ID instruction reads rt
//  id_rd        in   REG_W  resolved destination of ID instruction
//  id_regwrite  in   1      ID instruction writes register file
//  id_memread   in   1      ID instruction is a load
//  pipe_hold    in   1      global freeze (multi-cycle unit busy)
//  flush        in   1      taken branch/jump: squash ID instruction
//  stall        out  1      comb.; hold PC and IF/ID, bubble into ID/EX
//  fwd_a_sel    out  2      registered; operand-A mux select for EX instruction
//  fwd_b_sel    out  2      registered; operand-B mux select for EX instruction
// BEHAVIOUR
//  - State: ex_{v,rd,wr,ld}, mem_{v,rd,wr}, fwd_a_sel, fwd_b_sel.
//  - Reset: all shadow valid/wr/ld = 0, rd = 0, fwd_*_sel = 2'b00, counters = 0.
//  - stall = id_valid & ~flush & ex_v & ex_ld & ex_wr & (ex_rd != 0) &
//    ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)). Same cycle, comb.
//  - Per source S in {rs,rt}, select for next EX cycle (priority order):
//    01 if used & ex_v & ex_wr & ex_rd!=0 & ex_rd==S & ~ex_ld;
//    10 elif used & mem_v & mem_wr & mem_rd!=0 & mem_rd==S; else 00.
//  - Register 0 never forwarded; unused source always yields 00.
//  - Edge, pipe_hold=1: every register holds; stall still evaluated.
//  - Edge, pipe_hold=0: mem <= ex; ex <= ID fields if id_valid & ~stall & ~flush,
//    else bubble (v=wr=ld=0, rd=0); fwd_*_sel <= computed value, or 00 on bubble.
//  - flush & load-use together: flush wins, stall=0, bubble inserted.
//  - Latency: select valid exactly one cycle after instruction leaves ID; stalled
//    instruction re-evaluates next cycle and then gets 10 from the load.
//  - Reset asserted mid-stall: next cycle stall=0, selects 00, shadow empty.
// CONFIGURATION
//  FWD_PERF_CNT_EN defined: adds ports stall_cnt, fwd_cnt (out, CNT_W). stall_cnt
//   +1 each non-held cycle with stall=1; fwd_cnt +1 per non-bubble EX entry with
//   any nonzero select. Both saturate at all-ones; reset to 0.
//  Undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  - add $3 then add uses $3 as rs -> fwd_a_sel=01 next cycle, fwd_b_sel=00.
//  - add $3, nop, sub rt=$3 -> fwd_b_sel=10; add $3, add $3, use $3 -> 01 (youngest wins).
//  - lw $5 then add rs=$5 -> stall=1 one cycle, bubble in EX, then fwd_a_sel=10.
//  - writer of $0 followed by reader of $0 -> both selects 00, stall=0.
//  - lw $5 + dependent add with flush=1 same cycle -> stall=0, EX bubble, sel=00.
//  - pipe_hold=1 for 3 cycles during pending 01 -> selects/shadow unchanged;
//    reset mid-stall -> stall=0, sel=00 next cycle; with macro stall_cnt counts.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall control for the 5-stage pipeline.
// Define FWD_PERF_CNT_EN to add saturating stall/forward event counters.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             pipe_hold,
  input  logic             flush,
`ifdef FWD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt,
`endif
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
);

  logic             ex_v;
  logic [REG_W-1:0] ex_rd;
  logic             ex_wr;
  logic             ex_ld;
  logic             mem_v;
  logic [REG_W-1:0] mem_rd;
  logic             mem_wr;

  logic       ex_ld_hit;
  logic       ex_fwd_ok;
  logic       mem_fwd_ok;
  logic       take;
  logic [1:0] nxt_a;
  logic [1:0] nxt_b;

  // A load in EX cannot forward yet; only non-load writers qualify.
  assign ex_ld_hit = ex_v & ex_ld & ex_wr
                   & (ex_rd != '0);
  assign ex_fwd_ok = ex_v & ex_wr & ~ex_ld
                   & (ex_rd != '0);
  assign mem_fwd_ok = mem_v & mem_wr
                    & (mem_rd != '0);

  assign stall = id_valid & ~flush & ex_ld_hit
               & ((id_use_rs & (id_rs == ex_rd))
                | (id_use_rt & (id_rt == ex_rd)));

  assign take = id_valid & ~stall & ~flush;

  function automatic logic [1:0] pick(
    input logic             used,
    input logic [REG_W-1:0] s,
    input logic             exok,
    input logic [REG_W-1:0] exrd,
    input logic             memok,
    input logic [REG_W-1:0] memrd
  );
    logic [1:0] r;
    r = 2'b00;
    if (used & exok & (exrd == s))
      r = 2'b01;
    else if (used & memok & (memrd == s))
      r = 2'b10;
    return r;
  endfunction

  always_comb begin
    nxt_a = pick(id_use_rs, id_rs,
                 ex_fwd_ok, ex_rd,
                 mem_fwd_ok, mem_rd);
    nxt_b = pick(id_use_rt, id_rt,
                 ex_fwd_ok, ex_rd,
                 mem_fwd_ok, mem_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v      <= 1'b0;
      ex_rd     <= '0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      mem_v     <= 1'b0;
      mem_rd    <= '0;
      mem_wr    <= 1'b0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else if (!pipe_hold) begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      if (take) begin
        ex_v      <= 1'b1;
        ex_rd     <= id_rd;
        ex_wr     <= id_regwrite;
        ex_ld     <= id_memread;
        fwd_a_sel <= nxt_a;
        fwd_b_sel <= nxt_b;
      end else begin
        ex_v      <= 1'b0;
        ex_rd     <= '0;
        ex_wr     <= 1'b0;
        ex_ld     <= 1'b0;
        fwd_a_sel <= 2'b00;
        fwd_b_sel <= 2'b00;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!pipe_hold) begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (take && ((nxt_a != 2'b00) || (nxt_b != 2'b00))
          && (fwd_cnt != '1))
        fwd_cnt <= fwd_cnt + 1'b1;
    end
  end
`endif

endmodule
